// File: rtl/read_data_selection.sv
// rtl/read_data_selection.sv - read lane extraction with latency-matched valid pipeline
// Optional output register stage: define READ_DATA_SELECTION_OUTREG_EN.
module read_data_selection #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        re_i,
  input  logic [15:0] addr_i,
  input  logic [2:0]  output_config_i,
  input  logic        bist_active_i,
  input  logic [39:0] ram_rdata_i,
  output logic [39:0] rdata_o,
  output logic        rvalid_o,
  output logic        cfg_err_o
);

  localparam logic [2:0] CONFIG_1BIT  = 3'd1;
  localparam logic [2:0] CONFIG_2BIT  = 3'd2;
  localparam logic [2:0] CONFIG_5BIT  = 3'd3;
  localparam logic [2:0] CONFIG_10BIT = 3'd4;
  localparam logic [2:0] CONFIG_20BIT = 3'd5;
  localparam logic [2:0] CONFIG_40BIT = 3'd6;
  localparam logic [2:0] CONFIG_80BIT = 3'd7;

  // Stage 0 is loaded at the request edge; the last stage lines up with valid macro data.
  logic [READ_LATENCY:0] pipe_valid;
  logic [4:0]            pipe_lane [0:READ_LATENCY];
  logic [2:0]            pipe_cfg  [0:READ_LATENCY];
  logic                  pipe_bist [0:READ_LATENCY];

  logic        sel_valid;
  logic [39:0] sel_data;
  logic        accept;
  logic        unused_addr;

  assign accept      = en_i & re_i;
  assign unused_addr = ^addr_i[15:5];

  function automatic logic [39:0] select_lane(
    input logic [39:0] raw,
    input logic [4:0]  lane,
    input logic [2:0]  cfg,
    input logic        bist
  );
    logic [39:0] r;
    r = '0;
    if (bist) begin
      r = raw;
    end else begin
      case (cfg)
        CONFIG_1BIT:  r[0]    = raw[lane];
        CONFIG_2BIT:  r[1:0]  = raw[{lane[3:0], 1'b0} +: 2];
        CONFIG_5BIT:  r[4:0]  = raw[6'(lane[2:0]) * 6'd5 +: 5];
        CONFIG_10BIT: r[9:0]  = raw[6'(lane[1:0]) * 6'd10 +: 10];
        CONFIG_20BIT: r[19:0] = lane[0] ? raw[39:20] : raw[19:0];
        CONFIG_40BIT: r       = raw;
        CONFIG_80BIT: r       = raw;
        default:      r       = '0;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      sel_valid  <= 1'b0;
      sel_data   <= '0;
      cfg_err_o  <= 1'b0;
    end else begin
      pipe_valid[0] <= accept;
      if (accept) begin
        pipe_lane[0] <= addr_i[4:0];
        pipe_cfg[0]  <= output_config_i;
        pipe_bist[0] <= bist_active_i;
        if (output_config_i == 3'd0) begin
          cfg_err_o <= 1'b1;
        end
      end
      for (int i = 1; i <= int'(READ_LATENCY); i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_lane[i]  <= pipe_lane[i-1];
        pipe_cfg[i]   <= pipe_cfg[i-1];
        pipe_bist[i]  <= pipe_bist[i-1];
      end
      sel_valid <= pipe_valid[READ_LATENCY];
      if (pipe_valid[READ_LATENCY]) begin
        sel_data <= select_lane(ram_rdata_i, pipe_lane[READ_LATENCY],
                                pipe_cfg[READ_LATENCY], pipe_bist[READ_LATENCY]);
      end
    end
  end

`ifdef READ_DATA_SELECTION_OUTREG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= sel_valid;
      if (sel_valid) begin
        rdata_o <= sel_data;
      end
    end
  end
`else
  assign rvalid_o = sel_valid;
  assign rdata_o  = sel_data;
`endif

endmodule

// File: tb/tb_read_data_selection.sv
// tb/tb_read_data_selection.sv - directed self-checking bench for read_data_selection
// Expected latency follows READ_DATA_SELECTION_OUTREG_EN when it is defined.
module tb_read_data_selection;

  localparam int LAT = 2;
`ifdef READ_DATA_SELECTION_OUTREG_EN
  localparam int OUT_LAT = LAT + 2;
`else
  localparam int OUT_LAT = LAT + 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        re_i;
  logic [15:0] addr_i;
  logic [2:0]  output_config_i;
  logic        bist_active_i;
  logic [39:0] ram_rdata_i;
  logic [39:0] rdata_o;
  logic        rvalid_o;
  logic        cfg_err_o;

  int checks = 0;
  int errors = 0;

  read_data_selection #(.READ_LATENCY(LAT)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .en_i            (en_i),
    .re_i            (re_i),
    .addr_i          (addr_i),
    .output_config_i (output_config_i),
    .bist_active_i   (bist_active_i),
    .ram_rdata_i     (ram_rdata_i),
    .rdata_o         (rdata_o),
    .rvalid_o        (rvalid_o),
    .cfg_err_o       (cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one request, return at the negedge right after the request edge.
  task automatic issue_read(input logic [15:0] a, input logic [2:0] c, input logic b,
                            input logic [39:0] raw);
    @(negedge clk_i);
    en_i = 1'b1; re_i = 1'b1; addr_i = a; output_config_i = c;
    bist_active_i = b; ram_rdata_i = raw;
    @(posedge clk_i);
    @(negedge clk_i);
    en_i = 1'b0; re_i = 1'b0;
  endtask

  // Count negedges until rvalid_o is seen (bounded).
  task automatic wait_rvalid(output int cycles);
    cycles = 0;
    while (rvalid_o !== 1'b1 && cycles < 20) begin
      @(negedge clk_i);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b0; re_i = 1'b0; addr_i = '0; output_config_i = 3'd0;
    bist_active_i = 1'b0; ram_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (rdata_o !== 40'd0 || rvalid_o !== 1'b0 || cfg_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdata=%h rvalid=%b cfg_err=%b required 0/0/0", rdata_o, rvalid_o, cfg_err_o);
    end
  endtask

  task automatic test_lane_modes();
    logic [15:0] a_tab   [8] = '{16'h0003, 16'h0002, 16'hFFE1, 16'h0015, 16'hFFF6, 16'h1234, 16'h0000, 16'h0001};
    logic [2:0]  c_tab   [8] = '{3'd3, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd7, 3'd3};
    logic [39:0] raw_tab [8] = '{40'h00_000F_8000, 40'h0F_8000_7C00, 40'h00_0000_0002,
                                 40'h12_3456_789A, 40'h12_3456_789A, 40'hA5_5AC3_3C01,
                                 40'h01_2345_6789, 40'hFF_FFFF_FFFF};
    logic [39:0] exp_tab [8] = '{40'h1F, 40'h1F, 40'h1, 40'h2, 40'h345,
                                 40'hA5_5AC3_3C01, 40'h01_2345_6789, 40'h1F};
    int cyc;
    for (int i = 0; i < 8; i++) begin
      issue_read(a_tab[i], c_tab[i], 1'b0, raw_tab[i]);
      wait_rvalid(cyc);
      checks++;
      if (cyc != OUT_LAT) begin
        errors++;
        $display("FAIL lane_latency[%0d]: got %0d cycles required %0d", i, cyc, OUT_LAT);
      end
      checks++;
      if (rdata_o !== exp_tab[i]) begin
        errors++;
        $display("FAIL lane_data[%0d]: got %h required %h", i, rdata_o, exp_tab[i]);
      end
      @(negedge clk_i);
      checks++;
      if (rvalid_o !== 1'b0) begin
        errors++;
        $display("FAIL lane_pulse_width[%0d]: rvalid=%b required 0", i, rvalid_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int bad = 0;
    ram_rdata_i = 40'h00_AAAA_AAAA;
    output_config_i = 3'd1;
    bist_active_i = 1'b0;
    for (int t = 0; t < 32 + OUT_LAT + 3; t++) begin
      @(negedge clk_i);
      if (rvalid_o === 1'b1) begin
        if (rdata_o !== {39'd0, pulses[0]}) bad++;
        if (t != pulses + OUT_LAT + 1) bad++;
        pulses++;
      end
      en_i = (t < 32); re_i = (t < 32); addr_i = 16'(t);
    end
    checks++;
    if (pulses != 32) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses required 32", pulses);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_data: %0d bad pulses required 0", bad);
    end
  endtask

  task automatic test_config_freeze();
    int cyc;
    issue_read(16'h0001, 3'd5, 1'b0, 40'h12345_6789A);
    output_config_i = 3'd4;
    wait_rvalid(cyc);
    checks++;
    if (cyc != OUT_LAT || rdata_o !== 40'h00000_12345) begin
      errors++;
      $display("FAIL cfg_freeze: cycles=%0d data=%h required %0d/%h", cyc, rdata_o, OUT_LAT, 40'h00000_12345);
    end
  endtask

  task automatic test_bist();
    int cyc;
    issue_read(16'h0007, 3'd2, 1'b1, 40'hDE_ADBE_EF01);
    bist_active_i = 1'b0;
    wait_rvalid(cyc);
    checks++;
    if (cyc != OUT_LAT || rdata_o !== 40'hDE_ADBE_EF01) begin
      errors++;
      $display("FAIL bist: cycles=%0d data=%h required %0d/%h", cyc, rdata_o, OUT_LAT, 40'hDE_ADBE_EF01);
    end
  endtask

  task automatic test_reset_in_flight();
    int seen = 0;
    int cyc;
    ram_rdata_i = 40'h55_5555_5555;
    output_config_i = 3'd6;
    @(negedge clk_i);
    en_i = 1'b1; re_i = 1'b1; addr_i = 16'h0;
    repeat (3) @(negedge clk_i);
    en_i = 1'b0; re_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (rvalid_o === 1'b1) seen++;
      @(negedge clk_i);
    end
    checks++;
    if (seen != 0 || rdata_o !== 40'd0) begin
      errors++;
      $display("FAIL reset_flush: %0d pulses data=%h required 0/0", seen, rdata_o);
    end
    checks++;
    if (cfg_err_o !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_clear: got %b required 0", cfg_err_o);
    end
    issue_read(16'h0003, 3'd0, 1'b0, 40'hFF_FFFF_FFFF);
    checks++;
    if (cfg_err_o !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_set: got %b required 1", cfg_err_o);
    end
    wait_rvalid(cyc);
    checks++;
    if (cyc != OUT_LAT || rdata_o !== 40'd0) begin
      errors++;
      $display("FAIL cfg0_data: cycles=%0d data=%h required %0d/0", cyc, rdata_o, OUT_LAT);
    end
    issue_read(16'h0000, 3'd6, 1'b0, 40'h12_3456_789A);
    wait_rvalid(cyc);
    checks++;
    if (cfg_err_o !== 1'b1 || rdata_o !== 40'h12_3456_789A) begin
      errors++;
      $display("FAIL cfg_err_sticky: cfg_err=%b data=%h required 1/%h", cfg_err_o, rdata_o, 40'h12_3456_789A);
    end
  endtask

  task automatic test_enable_gate();
    int seen = 0;
    @(negedge clk_i);
    en_i = 1'b0; re_i = 1'b1; output_config_i = 3'd6;
    @(negedge clk_i);
    re_i = 1'b0;
    for (int k = 0; k < OUT_LAT + 3; k++) begin
      if (rvalid_o === 1'b1) seen++;
      @(negedge clk_i);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL enable_gate: %0d pulses required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_lane_modes();
    test_back_to_back();
    test_config_freeze();
    test_bist();
    test_enable_gate();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
